// File: rtl/ft600_pkg.sv
// Shared definitions for the FT600 245-synchronous-FIFO chip emulator.
// Holds the bus state encoding, the default widths and a constant-width helper.
package ft600_pkg;

  localparam int FT_DATA_WIDTH_DEF = 32;
  localparam int BE_WIDTH_DEF      = FT_DATA_WIDTH_DEF / 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2
  } bus_state_e;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/ft600_emu_if.sv
// FT600 245-synchronous bus as seen between the FPGA-side controller (master)
// and the chip emulator (slave).
interface ft600_emu_if
  import ft600_pkg::*;
#(
  parameter int FT_DATA_WIDTH = FT_DATA_WIDTH_DEF,
  parameter int BE_WIDTH      = BE_WIDTH_DEF
);
  logic                     rxf_n;
  logic                     txe_n;
  logic                     oe_n;
  logic                     rd_n;
  logic                     wr_n;
  logic [FT_DATA_WIDTH-1:0] data_i;
  logic [BE_WIDTH-1:0]      be_i;
  logic [FT_DATA_WIDTH-1:0] data_o;
  logic [BE_WIDTH-1:0]      be_o;
  logic                     bus_oe;

  modport master (
    input  rxf_n, txe_n, data_o, be_o, bus_oe,
    output oe_n, rd_n, wr_n, data_i, be_i
  );

  modport slave (
    output rxf_n, txe_n, data_o, be_o, bus_oe,
    input  oe_n, rd_n, wr_n, data_i, be_i
  );
endinterface

// File: rtl/ft_emu_fifo.sv
// Single-clock FIFO for the FT600 emulator; exposes the next-state count and the
// word that will sit at the head after the current edge, so callers can register them.
module ft_emu_fifo
  import ft600_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [WIDTH-1:0]      push_data,
  input  logic                  pop,
  output logic                  full,
  output logic                  empty,
  output logic [clog2(DEPTH):0] count_nxt,
  output logic [WIDTH-1:0]      head_nxt
);
  localparam int AW = clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    rd_ptr_inc;
  logic [AW:0]      count;
  logic             push_ok;
  logic             pop_ok;

  assign full       = (count == (AW+1)'(DEPTH));
  assign empty      = (count == '0);
  assign push_ok    = push & ~full;
  assign pop_ok     = pop & ~empty;
  assign rd_ptr_inc = rd_ptr + AW'(1);

  always_comb begin
    count_nxt = count;
    case ({push_ok, pop_ok})
      2'b10:   count_nxt = count + (AW+1)'(1);
      2'b01:   count_nxt = count - (AW+1)'(1);
      default: count_nxt = count;
    endcase
  end

  // A word written this edge is not yet in mem, so bypass it when it becomes the head.
  always_comb begin
    head_nxt = mem[rd_ptr];
    if (pop_ok)
      head_nxt = (count == (AW+1)'(1)) ? push_data : mem[rd_ptr_inc];
    else if (empty)
      head_nxt = push_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr_inc;
      count <= count_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/ft600_emu.sv
// FT600 chip-side emulator: answers an FPGA bus master with a host-to-FPGA and an
// FPGA-to-host buffer, both reachable from a host model over valid/ready streams.
module ft600_emu
  import ft600_pkg::*;
#(
  parameter int FT_DATA_WIDTH = FT_DATA_WIDTH_DEF,
  parameter int BE_WIDTH      = BE_WIDTH_DEF,
  parameter int RD_DEPTH      = 64,
  parameter int WR_DEPTH      = 64
) (
  input  logic                              clk,
  input  logic                              rst,
  ft600_emu_if.slave                        bus,
  input  logic [FT_DATA_WIDTH-1:0]          h2f_data,
  input  logic                              h2f_valid,
  output logic                              h2f_ready,
  output logic [FT_DATA_WIDTH+BE_WIDTH-1:0] f2h_data,
  output logic                              f2h_valid,
  input  logic                              f2h_ready,
  output logic                              proto_err,
  output logic [15:0]                       underrun_cnt
);
  localparam logic [1:0] S_IDLE = 2'(ST_IDLE);
  localparam logic [1:0] S_RD   = 2'(ST_RD);
  localparam logic [1:0] S_WR   = 2'(ST_WR);

  logic [1:0] st;
  logic [1:0] st_nxt;

  logic                              rd_full, rd_empty;
  logic [clog2(RD_DEPTH):0]          rd_count_nxt;
  logic [FT_DATA_WIDTH-1:0]          rd_head_nxt;
  logic                              wr_full, wr_empty;
  logic [clog2(WR_DEPTH):0]          wr_count_nxt;
  logic [FT_DATA_WIDTH+BE_WIDTH-1:0] wr_head_nxt;

  logic rd_pop, h2f_push, bus_push, f2h_pop, err_now, underrun_hit;

  assign rd_pop       = ~bus.oe_n & ~bus.rd_n & ~rd_empty;
  assign h2f_push     = h2f_valid & ~rd_full;
  assign bus_push     = ~bus.wr_n & ~wr_full;
  assign f2h_pop      = f2h_ready & ~wr_empty;
  assign underrun_hit = ~bus.oe_n & ~bus.rd_n & rd_empty;
  assign err_now      = (~bus.wr_n & ~bus.oe_n) | (~bus.rd_n & bus.oe_n) | (~bus.wr_n & wr_full);

  assign h2f_ready = ~rd_full;
  assign f2h_valid = ~wr_empty;
  assign bus.be_o  = '1;

  ft_emu_fifo #(.WIDTH(FT_DATA_WIDTH), .DEPTH(RD_DEPTH)) u_rd_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (h2f_push),
    .push_data (h2f_data),
    .pop       (rd_pop),
    .full      (rd_full),
    .empty     (rd_empty),
    .count_nxt (rd_count_nxt),
    .head_nxt  (rd_head_nxt)
  );

  ft_emu_fifo #(.WIDTH(FT_DATA_WIDTH + BE_WIDTH), .DEPTH(WR_DEPTH)) u_wr_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (bus_push),
    .push_data ({bus.be_i, bus.data_i}),
    .pop       (f2h_pop),
    .full      (wr_full),
    .empty     (wr_empty),
    .count_nxt (wr_count_nxt),
    .head_nxt  (wr_head_nxt)
  );

  always_comb begin
    st_nxt = st;
    case (st)
      S_IDLE: begin
        if (!bus.oe_n && bus.wr_n)      st_nxt = S_RD;
        else if (!bus.wr_n && bus.oe_n) st_nxt = S_WR;
      end
      S_RD:    if (bus.oe_n) st_nxt = S_IDLE;
      S_WR:    if (bus.wr_n) st_nxt = S_IDLE;
      default: st_nxt = S_IDLE;
    endcase
  end

  // data_o tracks the head while the chip owns the bus and holds once the buffer runs dry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st           <= S_IDLE;
      bus.rxf_n    <= 1'b1;
      bus.txe_n    <= 1'b0;
      bus.bus_oe   <= 1'b0;
      bus.data_o   <= '0;
      proto_err    <= 1'b0;
      underrun_cnt <= '0;
    end else begin
      st         <= st_nxt;
      bus.rxf_n  <= (rd_count_nxt == '0);
      bus.txe_n  <= (wr_count_nxt == (clog2(WR_DEPTH)+1)'(WR_DEPTH));
      bus.bus_oe <= ~bus.oe_n;
      if ((rd_pop || st_nxt == S_RD) && rd_count_nxt != '0)
        bus.data_o <= rd_head_nxt;
      if (err_now)
        proto_err <= 1'b1;
      if (underrun_hit && underrun_cnt != 16'hFFFF)
        underrun_cnt <= underrun_cnt + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    f2h_data <= wr_head_nxt;
  end

endmodule

// File: tb/tb_ft600_emu.sv
// Directed-plus-random bench for ft600_emu against a queue-based model of both buffers.
module tb_ft600_emu;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] h2f_data;
  logic        h2f_valid;
  logic        h2f_ready;
  logic [35:0] f2h_data;
  logic        f2h_valid;
  logic        f2h_ready;
  logic        proto_err;
  logic [15:0] underrun_cnt;

  ft600_emu_if #(.FT_DATA_WIDTH(32), .BE_WIDTH(4)) bus ();

  ft600_emu #(.FT_DATA_WIDTH(32), .BE_WIDTH(4), .RD_DEPTH(64), .WR_DEPTH(64)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .h2f_data     (h2f_data),
    .h2f_valid    (h2f_valid),
    .h2f_ready    (h2f_ready),
    .f2h_data     (f2h_data),
    .f2h_valid    (f2h_valid),
    .f2h_ready    (f2h_ready),
    .proto_err    (proto_err),
    .underrun_cnt (underrun_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] rq[$];
  logic [35:0] wq[$];
  logic        m_err;
  int          m_und;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic h2f_push(input logic [31:0] d);
    h2f_data  = d;
    h2f_valid = 1'b1;
    tick();
    h2f_valid = 1'b0;
    rq.push_back(d);
  endtask

  task automatic model_reset();
    rq.delete();
    wq.delete();
    m_err = 1'b0;
    m_und = 0;
  endtask

  logic        do_push, do_rd, do_wr, do_pop;
  logic [31:0] d;
  logic [3:0]  b;

  initial begin
    bus.oe_n = 1'b1; bus.rd_n = 1'b1; bus.wr_n = 1'b1;
    bus.data_i = '0; bus.be_i = '0;
    h2f_data = '0; h2f_valid = 1'b0; f2h_ready = 1'b0;
    model_reset();

    // Reset values
    tick(); tick();
    chk("rst_rxf_n", bus.rxf_n, 1'b1);
    chk("rst_txe_n", bus.txe_n, 1'b0);
    chk("rst_bus_oe", bus.bus_oe, 1'b0);
    chk("rst_data_o", bus.data_o, 32'h0);
    chk("rst_proto_err", proto_err, 1'b0);
    chk("rst_underrun", underrun_cnt, 16'h0);
    chk("rst_h2f_ready", h2f_ready, 1'b1);
    chk("rst_f2h_valid", f2h_valid, 1'b0);
    rst = 1'b0;
    tick();

    // Host pushes four words; rxf_n falls after the first
    for (int i = 1; i <= 4; i++) begin
      h2f_push(32'h11111100 + 32'(i));
      if (i == 1) chk("rxf_after_first_push", bus.rxf_n, 1'b0);
    end

    // Bus read: oe_n first, then four back-to-back rd_n strobes
    bus.oe_n = 1'b0;
    tick();
    chk("bus_oe_rd", bus.bus_oe, 1'b1);
    bus.rd_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("burst_data", bus.data_o, rq.pop_front());
      tick();
    end
    chk("rxf_after_last_pop", bus.rxf_n, 1'b1);

    // Three more strobes on the now-empty buffer
    tick(); tick(); tick();
    m_und += 3;
    chk("underrun_cnt", underrun_cnt, 16'(m_und));
    chk("underrun_data_hold", bus.data_o, 32'h11111104);
    chk("underrun_no_err", proto_err, m_err);
    bus.rd_n = 1'b1; bus.oe_n = 1'b1;
    tick();
    chk("bus_oe_released", bus.bus_oe, 1'b0);

    // Fill the FPGA-to-host buffer from the bus
    bus.be_i = 4'hF;
    bus.wr_n = 1'b0;
    for (int i = 0; i < 64; i++) begin
      bus.data_i = 32'(i);
      tick();
      wq.push_back({4'hF, 32'(i)});
      if (i == 62) chk("txe_before_full", bus.txe_n, 1'b0);
    end
    chk("txe_when_full", bus.txe_n, 1'b1);
    chk("no_err_before_overflow", proto_err, m_err);
    bus.data_i = 32'hDEADBEEF;
    tick();
    m_err = 1'b1;
    bus.wr_n = 1'b1;
    chk("overflow_proto_err", proto_err, m_err);
    f2h_ready = 1'b1;
    for (int i = 0; i < 64; i++) begin
      chk("f2h_valid_drain", f2h_valid, 1'b1);
      chk("f2h_data_drain", f2h_data, wq.pop_front());
      tick();
    end
    f2h_ready = 1'b0;
    chk("f2h_empty_after_64", f2h_valid, 1'b0);
    chk("txe_after_drain", bus.txe_n, 1'b0);

    // Reset clears the sticky flag
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_reset();
    chk("err_cleared_by_rst", proto_err, m_err);

    // Write with oe_n low: the word still lands, and the bus error sticks
    bus.wr_n = 1'b0; bus.oe_n = 1'b0;
    bus.data_i = 32'h5A5A5A5A; bus.be_i = 4'h3;
    tick();
    wq.push_back({4'h3, 32'h5A5A5A5A});
    m_err = 1'b1;
    bus.wr_n = 1'b1; bus.oe_n = 1'b1;
    tick();
    chk("wr_oe_proto_err", proto_err, m_err);

    // Random host pushes interleaved with bus reads
    bus.oe_n = 1'b0;
    tick();
    for (int c = 0; c < 120; c++) begin
      do_push = ($urandom_range(0, 1) == 1) && (rq.size() < 64);
      do_rd   = ($urandom_range(0, 2) != 0) && (rq.size() > 0);
      d       = $urandom;
      h2f_data  = d;
      h2f_valid = do_push;
      bus.rd_n  = ~do_rd;
      chk("rand_h2f_ready", h2f_ready, rq.size() < 64);
      if (do_rd) chk("rand_rd_data", bus.data_o, rq[0]);
      tick();
      if (do_rd) void'(rq.pop_front());
      if (do_push) rq.push_back(d);
      chk("rand_rxf_n", bus.rxf_n, rq.size() == 0);
    end
    h2f_valid = 1'b0;
    bus.rd_n = 1'b1; bus.oe_n = 1'b1;
    tick();

    // Random bus writes interleaved with host pops
    for (int c = 0; c < 120; c++) begin
      do_wr  = ($urandom_range(0, 1) == 1) && (wq.size() < 64);
      do_pop = ($urandom_range(0, 1) == 1);
      d      = $urandom;
      b      = 4'($urandom_range(0, 15));
      bus.wr_n   = ~do_wr;
      bus.data_i = d;
      bus.be_i   = b;
      f2h_ready  = do_pop;
      chk("rand_f2h_valid", f2h_valid, wq.size() > 0);
      chk("rand_txe_n", bus.txe_n, wq.size() == 64);
      if (do_pop && wq.size() > 0) chk("rand_f2h_data", f2h_data, wq[0]);
      tick();
      if (do_pop && wq.size() > 0) void'(wq.pop_front());
      if (do_wr) wq.push_back({b, d});
    end
    bus.wr_n = 1'b1; f2h_ready = 1'b0;
    tick();
    chk("err_sticky_after_traffic", proto_err, m_err);

    // Reset in the middle of a ten-word read burst
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 10; i++) h2f_push($urandom);
    bus.oe_n = 1'b0;
    tick();
    bus.rd_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("midburst_data", bus.data_o, rq.pop_front());
      tick();
    end
    #2 rst = 1'b1;
    #1;
    model_reset();
    chk("midrst_bus_oe", bus.bus_oe, 1'b0);
    chk("midrst_rxf_n", bus.rxf_n, 1'b1);
    chk("midrst_data_o", bus.data_o, 32'h0);
    chk("midrst_underrun", underrun_cnt, 16'(m_und));
    chk("midrst_f2h_valid", f2h_valid, 1'b0);
    bus.rd_n = 1'b1; bus.oe_n = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    chk("post_rst_rxf_n", bus.rxf_n, 1'b1);
    h2f_push(32'hCAFEF00D);
    bus.oe_n = 1'b0;
    tick();
    bus.rd_n = 1'b0;
    chk("post_rst_data", bus.data_o, rq.pop_front());
    tick();
    bus.rd_n = 1'b1; bus.oe_n = 1'b1;
    chk("post_rst_rxf_empty", bus.rxf_n, 1'b1);
    chk("post_rst_no_err", proto_err, m_err);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
